fetch_pair_queue: RTL

- Instruction fetch stage directly upstream of the branch generation unit.
- Holds the fetch PC and issues word reads to the synchronous instruction memory. Each word is one even/odd pair of 16-bit instructions.
- Buffers returned pairs in a small FIFO and presents the head pair (p0/p1 IR plus its PC) to the BGU/decode stage.
- Takes redirects (the BGU's next PC when a branch is taken), flushes stale pairs and drops in-flight reads.

---
 rtl/fetch_pair_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_pair_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pair_queue
//  Description : Instruction fetch stage ahead of the branch generation unit.
//                Issues word reads (one even/odd pair of 16-bit instructions)
//                to a synchronous instruction memory. Returned pairs go into a
//                small FIFO, and the head pair is presented downstream.
//                A redirect flushes the FIFO and drops the in-flight read.
//  Options     : FETCH_PAIR_QUEUE_BYPASS_EN - when the FIFO is empty, a
//                returning pair is presented combinationally in the cycle it
//                arrives.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_pair_queue #(
    parameter int          DEPTH  = 4,
    parameter logic [15:0] NOP_IR = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,            // asynchronous, active low
    input  logic                       redirect_in,
    input  logic [8:0]                 redirect_pc_in,
    input  logic                       consume_in,
    output logic                       imem_rd_en_out,
    output logic [7:0]                 imem_addr_out,
    input  logic [31:0]                imem_rdata_in,
    output logic [15:0]                p0_IR_out,
    output logic [15:0]                p1_IR_out,
    output logic [8:0]                 pair_pc_out,
    output logic                       pair_valid_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_OW = c_CW + 1;

    // Fetch PC, in-flight read tracking and flush epoch
    logic [8:0]      r_fpc;
    logic            r_infl;
    logic [8:0]      r_infl_pc;
    logic            r_infl_epoch;
    logic            r_epoch;

    // FIFO control and storage
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [31:0]     r_fifo_data [DEPTH];
    logic [8:0]      r_fifo_pc   [DEPTH];

    logic            w_pop;
    logic            w_ret;
    logic            w_bypass;
    logic            w_push;
    logic            w_issue;
    logic [c_OW-1:0] w_occ;
    logic [c_OW-1:0] w_room;

    // A pop only happens when a valid pair sits at the head
    assign w_pop = consume_in & (r_count != '0) & ~redirect_in;

    // Returning data is kept only if no flush happened since it was issued
    assign w_ret = r_infl & (r_infl_epoch == r_epoch) & ~redirect_in;

`ifdef FETCH_PAIR_QUEUE_BYPASS_EN
    assign w_bypass = w_ret & (r_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed pair consumed in the same cycle never enters the FIFO
    assign w_push = w_ret & ~(w_bypass & consume_in);

    // Issue only if the read is guaranteed a free slot when it returns;
    // a pop in this cycle frees one slot.
    assign w_occ   = c_OW'(r_count) + c_OW'(r_infl);
    assign w_room  = c_OW'(DEPTH) + c_OW'(w_pop);
    assign w_issue = rst & ~redirect_in & (w_occ < w_room);

    assign imem_rd_en_out = w_issue;
    assign imem_addr_out  = r_fpc[8:1];
    assign count_out      = r_count;

    // Fetch PC, in-flight read, epoch and FIFO pointer/occupancy state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc        <= 9'd0;
            r_infl       <= 1'b0;
            r_infl_pc    <= 9'd0;
            r_infl_epoch <= 1'b0;
            r_epoch      <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else if (redirect_in) begin
            r_fpc    <= redirect_pc_in & 9'h1FE;
            r_infl   <= 1'b0;
            r_epoch  <= ~r_epoch;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            r_infl  <= w_issue;
            if (w_issue) begin
                r_infl_pc    <= r_fpc;
                r_infl_epoch <= r_epoch;
                r_fpc        <= r_fpc + 9'd2;
            end
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates use
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= imem_rdata_in;
            r_fifo_pc[r_wr_ptr]   <= r_infl_pc;
        end
    end

    // Present the head pair, a bypassed return, or NOP when nothing is valid
    always_comb begin
        p0_IR_out      = NOP_IR;
        p1_IR_out      = NOP_IR;
        pair_pc_out    = 9'd0;
        pair_valid_out = 1'b0;
        if (r_count != '0) begin
            p0_IR_out      = r_fifo_data[r_rd_ptr][15:0];
            p1_IR_out      = r_fifo_data[r_rd_ptr][31:16];
            pair_pc_out    = r_fifo_pc[r_rd_ptr];
            pair_valid_out = 1'b1;
        end else if (w_bypass) begin
            p0_IR_out      = imem_rdata_in[15:0];
            p1_IR_out      = imem_rdata_in[31:16];
            pair_pc_out    = r_infl_pc;
            pair_valid_out = 1'b1;
        end
    end

endmodule
`default_nettype wire
